// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file with scoreboard.
package regfile_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned NREGS_DEFAULT = 32;
  localparam int unsigned REG_ZERO      = 0;

  // Width needed to hold a count from 0 to n inclusive, never below 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: zero-register override, writeback bypass, then array/busy lookup.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEFAULT,
  parameter int unsigned NREGS    = NREGS_DEFAULT,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic [AW-1:0]               addr,
  input  logic [NREGS-1:0][XLEN-1:0]  regs,
  input  logic [NREGS-1:0]            busy,
  input  logic                        wb_en,
  input  logic [AW-1:0]               wb_addr,
  input  logic [XLEN-1:0]             wb_data,
  output logic [XLEN-1:0]             data_c,
  output logic                        busy_c
);

  logic is_zero;

  assign is_zero = (ZERO_REG != 0) && (addr == AW'(REG_ZERO));

  always_comb begin
    data_c = regs[addr];
    busy_c = busy[addr];
    if (is_zero) begin
      data_c = '0;
      busy_c = 1'b0;
    end else if (wb_en && (wb_addr == addr)) begin
      // The producer completes this cycle, so the consumer sees the value and no hazard.
      data_c = wb_data;
      busy_c = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with same-cycle writeback bypass and a pending-write scoreboard.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEFAULT,
  parameter int unsigned NREGS    = NREGS_DEFAULT,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(NREGS),
  localparam int unsigned CW      = cnt_width(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 wb_en,
  input  logic [AW-1:0]        wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 alloc_en,
  input  logic [AW-1:0]        alloc_addr,
  output logic [CW-1:0]        busy_cnt
);

  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:0]           busy_q, busy_d;
  logic [CW-1:0]              busy_cnt_q, busy_cnt_d;
  logic                       wb_ok, alloc_ok, wb_bypass_en;

  assign wb_ok    = wb_en    && !((ZERO_REG != 0) && (wb_addr    == AW'(REG_ZERO)));
  assign alloc_ok = alloc_en && !((ZERO_REG != 0) && (alloc_addr == AW'(REG_ZERO)));

  // Bypass is blocked during reset so reads show the cleared state only.
  assign wb_bypass_en = wb_en && !rst;

  // Next array/scoreboard state; alloc applied after wb so a same-address set wins.
  always_comb begin
    regs_d     = regs_q;
    busy_d     = busy_q;
    busy_cnt_d = '0;
    if (wb_ok) begin
      regs_d[wb_addr] = wb_data;
      busy_d[wb_addr] = 1'b0;
    end
    if (alloc_ok) begin
      busy_d[alloc_addr] = 1'b1;
    end
    for (int unsigned i = 0; i < NREGS; i++) begin
      busy_cnt_d = busy_cnt_d + CW'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q     <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    regfile_rdport #(
      .XLEN     (XLEN),
      .NREGS    (NREGS),
      .ZERO_REG (ZERO_REG)
    ) u_rdport (
      .addr    (rd_addr[p*AW +: AW]),
      .regs    (regs_q),
      .busy    (busy_q),
      .wb_en   (wb_bypass_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .data_c  (rd_data[p*XLEN +: XLEN]),
      .busy_c  (rd_busy[p])
    );
  end

endmodule
